// File: rtl/mult8_seq_unit.sv
// Sequential 8x8 unsigned shift-add multiplier with start/locked/done handshake,
// operand echo, and an optional rotating seven-segment digit scan (macro SEG_SCAN_EN).
module mult8_seq_unit #(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        locked,
  output logic [15:0] d_out,
  output logic        done_flag,
  output logic [7:0]  seg_position,
  output logic [7:0]  verif_a,
  output logic [7:0]  verif_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("mult8_seq_unit: SCAN_DIV must be 1 or more");
  end

  state_t      state_q;
  logic [15:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [15:0] acc_q;
  logic [2:0]  iter_q;
  logic        locked_q;
  logic        done_q;
  logic [15:0] d_out_q;
  logic [7:0]  verif_a_q;
  logic [7:0]  verif_b_q;
  logic [15:0] acc_d;

  // Accumulator value after the current iteration; also the final product on the 8th.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 16'd0;
      mplier_q  <= 8'd0;
      acc_q     <= 16'd0;
      iter_q    <= 3'd0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      d_out_q   <= 16'd0;
      verif_a_q <= 8'd0;
      verif_b_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            verif_a_q <= a;
            verif_b_q <= b;
            mcand_q   <= {8'd0, a};
            mplier_q  <= b;
            acc_q     <= 16'd0;
            iter_q    <= 3'd0;
            locked_q  <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
          iter_q   <= iter_q + 3'd1;
          if (iter_q == 3'd7) begin
            d_out_q <= acc_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          locked_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign locked    = locked_q;
  assign done_flag = done_q;
  assign d_out     = d_out_q;
  assign verif_a   = verif_a_q;
  assign verif_b   = verif_b_q;

`ifdef SEG_SCAN_EN
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt_q;
  logic [7:0]    seg_q;

  // Free-running: the single low bit advances one digit every SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      seg_q      <= 8'b1111_1110;
    end else if (scan_cnt_q == DIV_LAST) begin
      scan_cnt_q <= '0;
      seg_q      <= {seg_q[6:0], seg_q[7]};
    end else begin
      scan_cnt_q <= scan_cnt_q + CW'(1);
    end
  end

  assign seg_position = seg_q;
`else
  assign seg_position = 8'b1111_1110;
`endif

endmodule

// File: tb/tb_mult8_seq_unit.sv
// Self-checking bench for mult8_seq_unit: vector table, corner sequences and
// randomized back-to-back operation against a cycle-timeline reference model.
module tb_mult8_seq_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        locked;
  logic [15:0] d_out;
  logic        done_flag;
  logic [7:0]  seg_position;
  logic [7:0]  verif_a;
  logic [7:0]  verif_b;

  mult8_seq_unit #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a            (a),
    .b            (b),
    .locked       (locked),
    .d_out        (d_out),
    .done_flag    (done_flag),
    .seg_position (seg_position),
    .verif_a      (verif_a),
    .verif_b      (verif_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: an operation accepted at edge E0 finishes after E8, idles after E9.
  bit          m_active;
  int          m_k;
  int          m_ea;
  int          m_eb;
  int          m_dout;
  int          m_va;
  int          m_vb;
  int          seg_n;
  bit          seg_valid;
  bit          prev_done;
  int          done_count;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_expected(input int n);
    logic [7:0] one;
`ifdef SEG_SCAN_EN
    one = 8'b1 << ((n / 4) % 8);
`else
    one = 8'b1;
`endif
    return ~one;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_k = 0; m_dout = 0; m_va = 0; m_vb = 0;
      seg_n = 0; seg_valid = 1;
    end else begin
      seg_n++;
      if (m_active) begin
        m_k++;
        if (m_k == 8) m_dout = m_ea * m_eb;
        if (m_k == 9) m_active = 0;
      end else if (start) begin
        m_ea = a; m_eb = b; m_va = a; m_vb = b;
        m_active = 1; m_k = 0;
      end
    end
    @(negedge clk);
    check("locked", locked, m_active);
    check("done_flag", done_flag, (m_active && m_k == 8));
    check("d_out", d_out, m_dout);
    check("verif_a", verif_a, m_va);
    check("verif_b", verif_b, m_vb);
    check("done_not_back_to_back", done_flag & prev_done, 0);
    if (seg_valid) check("seg_position", seg_position, seg_expected(seg_n));
    if (done_flag) done_count++;
    prev_done = done_flag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd129, 8'd19,  16'd2451};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd1,   8'd1,   16'd1};
    vecs[4] = '{8'd200, 8'd0,   16'd0};
    vecs[5] = '{8'd128, 8'd2,   16'd256};
    vecs[6] = '{8'd17,  8'd15,  16'd255};

    rst = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
    m_active = 0; m_k = 0; m_dout = 0; m_va = 0; m_vb = 0;
    seg_n = 0; seg_valid = 0; prev_done = 0; done_count = 0;
    @(negedge clk);
    do_reset();
    check("reset_d_out", d_out, 16'd0);
    check("reset_locked", locked, 1'b0);
    check("reset_seg", seg_position, 8'hFE);

    // Vector table: one-cycle start pulse, then operands scrambled while running.
    for (int i = 0; i < 7; i++) begin
      a = vecs[i].va; b = vecs[i].vb; start = 1'b1;
      cycle();
      start = 1'b0; a = ~vecs[i].va; b = 8'h5A;
      done_count = 0;
      for (int c = 0; c < 10; c++) cycle();
      check("vec_product", d_out, vecs[i].prod);
      check("vec_verif_a", verif_a, vecs[i].va);
      check("vec_verif_b", verif_b, vecs[i].vb);
      check("vec_done_pulses", done_count, 1);
      $display("[TB] vec %0d: %0d*%0d -> d_out=%0d", i, vecs[i].va, vecs[i].vb, d_out);
    end

    // Start while locked must be ignored.
    a = 8'd10; b = 8'd10; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    a = 8'd3; b = 8'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    check("ignored_start_d_out", d_out, 16'd100);
    check("ignored_start_verif_a", verif_a, 8'd10);
    $display("[TB] ignored-start sequence: d_out=%0d verif_a=%0d", d_out, verif_a);

    // Reset mid-operation: no completion, outputs cleared, then normal operation.
    a = 8'd77; b = 8'd91; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_d_out", d_out, 16'd0);
    check("abort_verif_a", verif_a, 8'd0);
    done_count = 0;
    for (int c = 0; c < 12; c++) cycle();
    check("abort_no_done", done_count, 0);
    a = 8'd77; b = 8'd91; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    check("after_abort_product", d_out, 16'd7007);
    $display("[TB] reset-abort sequence: d_out after recovery=%0d", d_out);

    // Randomized: start held high, operands changing every cycle.
    start = 1'b1;
    done_count = 0;
    for (int c = 0; c < 200; c++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cycle();
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    check("random_done_count", done_count, 20);
    $display("[TB] random back-to-back: %0d completions", done_count);

    // Long idle stretch to exercise the digit scan wrap.
    for (int c = 0; c < 40; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
